wireshark_onchip_mem_arbiter: RTL and testbench
===============================================

WIRESHARK_ONCHIP_MEM_ARBITER -- requirements
Module: wireshark_onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the shared 4096x32 on-chip RAM.
REQ-002 Parameter DATA_W, default 32, data width; BE_W = DATA_W/8, default 4.
REQ-003 Parameter MAX_HOLD, default 4, max consecutive grants to one requester while the other waits (range 1..15).
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mN_address (N=0,1)  in  ADDR_W  requester N word address.
REQ-007 mN_byteenable  in  BE_W  requester N byte lanes for writes.
REQ-008 mN_read / mN_write  in  1 each  requester N read / write request, held until accepted.
REQ-009 mN_writedata  in  DATA_W  requester N write data.
REQ-010 mN_waitrequest  out  1  high = request not accepted this cycle.
REQ-011 mN_readdata  out  DATA_W  read return data.
REQ-012 mN_readdatavalid  out  1  one-cycle strobe qualifying mN_readdata.
REQ-013 mem_address / mem_byteenable / mem_writedata  out  ADDR_W / BE_W / DATA_W  RAM port drive.
REQ-014 mem_chipselect / mem_write  out  1 each  RAM access strobe / write enable.
REQ-015 mem_readdata  in  DATA_W  RAM read data, valid one cycle after address (unregistered output, latency 1).

Function
REQ-016 reqN = mN_read | mN_write; at most one access is issued to RAM per cycle.
REQ-017 Grant is combinational from reqN, last_owner and hold_cnt: only one requesting -> it wins; both requesting -> last_owner wins if hold_cnt < MAX_HOLD, else the other requester wins.
REQ-018 mN_waitrequest = reqN & ~grantN; an idle requester sees waitrequest low.
REQ-019 Granted request drives mem_* in the same cycle; mem_chipselect = grant0|grant1; mem_write = granted requester's write.
REQ-020 mN_read and mN_write asserted together: write executes, read is dropped, no readdatavalid returned (illegal; bench asserts it never occurs).
REQ-021 Accepted read in cycle T -> mN_readdatavalid high in T+1 only, mN_readdata = mem_readdata in T+1; other requester's readdatavalid stays low.
REQ-022 Read-return tracking uses registers rd_pend, rd_owner; back-to-back reads (same or alternating owners) are returned every cycle with no bubble.
REQ-023 On a grant to g: g == last_owner -> hold_cnt increments, saturating at MAX_HOLD; else last_owner <= g, hold_cnt <= 1.
REQ-024 Cycle with no request: hold_cnt <= 0, last_owner unchanged.
REQ-025 mN_readdata drives mem_readdata continuously; only readdatavalid qualifies it.
REQ-026 Writes have no response; a write in T and a read of the same address in T+1 returns the new data.

Reset
REQ-027 While reset is high: last_owner = 0, hold_cnt = 0, rd_pend = 0, rd_owner = 0.
REQ-028 While reset is high: grants forced low, mem_chipselect = 0, mem_write = 0, both waitrequests = reqN, both readdatavalid = 0.
REQ-029 Read accepted in the cycle before reset asserts produces no readdatavalid.
REQ-030 After reset, the first tie goes to m0.

Structure
REQ-031 Shared package wireshark_mem_pkg holds ADDR_W/DATA_W defaults, the owner encoding (OWN_M0 = 0, OWN_M1 = 1) and the hold_cnt width constant.
REQ-032 One sub-module, wireshark_rr_hold_arb, holds the grant decision, last_owner and hold_cnt; the top holds the mux and read-return pipeline.

Verification
REQ-033 m0 only, write 0xDEADBEEF to 0x010 with BE 4'b1111, then read 0x010 -> waitrequest low both cycles; m0_readdatavalid one cycle later with 0xDEADBEEF.
REQ-034 Both read continuously, MAX_HOLD = 4 -> grant pattern m0 x4, m1 x4, m0 x4; waitrequest high on the loser; each readdatavalid exactly one cycle after its acceptance.
REQ-035 MAX_HOLD = 1, both write continuously -> strict alternation m0, m1, m0, m1; RAM sees 2 writes per 2 cycles, no idle cycles.
REQ-036 m0 read to 0xFFF accepted, reset asserted next cycle -> no readdatavalid; after release, tie grants m0 first.
REQ-037 m1 write 0x12345678 with BE 4'b0011 to 0x020 over 0xFFFFFFFF, then m0 reads 0x020 -> m0_readdata 0xFFFF5678.
REQ-038 m0 holds 3 grants, one idle cycle, then both request -> hold_cnt reset, m0 (last_owner) wins next 4 grants.

Source files
------------

// File: rtl/wireshark_mem_pkg.sv
// Shared constants and owner encoding for the two-port on-chip RAM arbiter.
package wireshark_mem_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int HOLD_W     = 4;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  function automatic logic [HOLD_W-1:0] hold_inc_sat(input logic [HOLD_W-1:0] cnt,
                                                     input logic [HOLD_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/wireshark_rr_hold_arb.sv
// Two-requester arbiter: sticky to the last owner until it has held MAX_HOLD
// consecutive grants while the other requester waits.
module wireshark_rr_hold_arb
  import wireshark_mem_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  owner_e            last_owner;
  logic [HOLD_W-1:0] hold_cnt;
  logic              keep;
  owner_e            grant_owner;

  always_comb begin
    grant0      = 1'b0;
    grant1      = 1'b0;
    keep        = (hold_cnt < HOLD_LIM);
    grant_owner = OWN_M0;
    if (!reset) begin
      if (req0 && req1) begin
        // Tie: the last owner keeps the port while under its hold budget.
        if ((last_owner == OWN_M0) == keep) grant0 = 1'b1;
        else                                grant1 = 1'b1;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
    if (grant1) grant_owner = OWN_M1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= OWN_M0;
      hold_cnt   <= '0;
    end else if (grant0 || grant1) begin
      if (grant_owner == last_owner) begin
        hold_cnt <= hold_inc_sat(hold_cnt, HOLD_LIM);
      end else begin
        last_owner <= grant_owner;
        hold_cnt   <= HOLD_W'(1);
      end
    end else begin
      hold_cnt <= '0;
    end
  end

endmodule

// File: rtl/wireshark_onchip_mem_arbiter.sv
// Shares one single-port RAM (read latency 1) between two Avalon-style
// requesters; holds the request mux and the read-return tracking.
module wireshark_onchip_mem_arbiter
  import wireshark_mem_pkg::*;
#(
  parameter int  ADDR_W   = DEF_ADDR_W,
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  MAX_HOLD = 4,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic   req0, req1;
  logic   grant0, grant1;
  logic   rd_accept;
  owner_e rd_owner_nxt;
  logic   rd_pend;
  owner_e rd_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  wireshark_rr_hold_arb #(
    .MAX_HOLD (MAX_HOLD)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
    mem_chipselect = grant0 | grant1;
    mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
    // A read issued together with a write is dropped; the write wins.
    rd_accept      = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
    rd_owner_nxt   = grant1 ? OWN_M1 : OWN_M0;
  end

  // Read-return stage: RAM data appears one cycle after the accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_M0;
    end else begin
      rd_pend <= rd_accept;
      if (rd_accept) rd_owner <= rd_owner_nxt;
    end
  end

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend & ~reset & (rd_owner == OWN_M0);
  assign m1_readdatavalid = rd_pend & ~reset & (rd_owner == OWN_M1);

endmodule

// File: tb/tb_wireshark_onchip_mem_arbiter.sv
// Bench for wireshark_onchip_mem_arbiter: per-cycle vector table, RAM model and
// a read-return scoreboard; a second instance with MAX_HOLD=1 checks alternation.
module tb_wireshark_onchip_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;

  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic          mem_chipselect, mem_write;
  logic [DW-1:0] mem_readdata;

  logic          alt_m0_waitrequest, alt_m1_waitrequest;
  logic [DW-1:0] alt_m0_readdata, alt_m1_readdata;
  logic          alt_m0_readdatavalid, alt_m1_readdatavalid;
  logic [AW-1:0] alt_mem_address;
  logic [BW-1:0] alt_mem_byteenable;
  logic [DW-1:0] alt_mem_writedata;
  logic          alt_mem_chipselect, alt_mem_write;
  logic [DW-1:0] alt_mem_readdata;

  assign alt_mem_readdata = 32'h0BAD_F00D;

  always #5 clk = ~clk;

  wireshark_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_readdata(mem_readdata)
  );

  wireshark_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(1)) dut_alt (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(alt_m0_waitrequest),
    .m0_readdata(alt_m0_readdata), .m0_readdatavalid(alt_m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(alt_m1_waitrequest),
    .m1_readdata(alt_m1_readdata), .m1_readdatavalid(alt_m1_readdatavalid),
    .mem_address(alt_mem_address), .mem_byteenable(alt_mem_byteenable),
    .mem_writedata(alt_mem_writedata), .mem_chipselect(alt_mem_chipselect),
    .mem_write(alt_mem_write), .mem_readdata(alt_mem_readdata)
  );

  // RAM model: registered read, so data follows the address by one cycle.
  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] ram_q;
  assign mem_readdata = ram_q;

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [BW-1:0] be0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [BW-1:0] be1;
    int            g;   // expected grant: 0 none, 1 m0, 2 m1
  } vec_t;

  typedef struct {
    int            due;
    logic          owner;
    logic [DW-1:0] data;
  } sb_t;

  vec_t          vecs[$];
  sb_t           sbq[$];
  sb_t           ent;
  logic [DW-1:0] shadow [0:4095];
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;

  function automatic vec_t mk(input logic r0, input logic w0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic [BW-1:0] be0,
                              input logic r1, input logic w1, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d1, input logic [BW-1:0] be1, input int g);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
    v.g  = g;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic shadow_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    for (int b = 0; b < BW; b++)
      if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic check_returns();
    logic          ev0, ev1;
    logic [DW-1:0] ed;
    ev0 = 1'b0; ev1 = 1'b0; ed = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      ent = sbq.pop_front();
      ed  = ent.data;
      if (ent.owner) ev1 = 1'b1;
      else           ev0 = 1'b1;
    end
    chk1("m0_readdatavalid", m0_readdatavalid, ev0);
    chk1("m1_readdatavalid", m1_readdatavalid, ev1);
    if (ev0) chk("m0_readdata", m0_readdata, ed);
    if (ev1) chk("m1_readdata", m1_readdata, ed);
  endtask

  task automatic drive(input vec_t v);
    reset = 1'b0;
    m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_writedata = v.d0; m0_byteenable = v.be0;
    m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_writedata = v.d1; m1_byteenable = v.be1;
    @(negedge clk);
    if ((m0_read && m0_write) || (m1_read && m1_write)) begin
      errors++;
      $display("FAIL read_and_write_together cycle %0d", cyc);
    end
    check_returns();
    chk1("m0_waitrequest", m0_waitrequest, (v.r0 | v.w0) && (v.g != 1));
    chk1("m1_waitrequest", m1_waitrequest, (v.r1 | v.w1) && (v.g != 2));
    chk1("mem_chipselect", mem_chipselect, v.g != 0);
    if (v.g == 1) begin
      chk1("mem_write", mem_write, v.w0);
      chk("mem_address", 32'(mem_address), 32'(v.a0));
      if (v.w0) shadow_write(v.a0, v.d0, v.be0);
      else if (v.r0) sbq.push_back('{due: cyc + 1, owner: 1'b0, data: shadow[v.a0]});
    end else if (v.g == 2) begin
      chk1("mem_write", mem_write, v.w1);
      chk("mem_address", 32'(mem_address), 32'(v.a1));
      if (v.w1) shadow_write(v.a1, v.d1, v.be1);
      else if (v.r1) sbq.push_back('{due: cyc + 1, owner: 1'b1, data: shadow[v.a1]});
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic reset_cycle(input logic r0, input logic r1);
    reset = 1'b1;
    m0_read = r0; m0_write = 1'b0; m0_address = 12'hFFF; m0_writedata = '0; m0_byteenable = '0;
    m1_read = r1; m1_write = 1'b0; m1_address = 12'h020; m1_writedata = '0; m1_byteenable = '0;
    sbq.delete();
    @(negedge clk);
    chk1("rst_m0_waitrequest", m0_waitrequest, r0);
    chk1("rst_m1_waitrequest", m1_waitrequest, r1);
    chk1("rst_m0_readdatavalid", m0_readdatavalid, 1'b0);
    chk1("rst_m1_readdatavalid", m1_readdatavalid, 1'b0);
    chk1("rst_mem_chipselect", mem_chipselect, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;

    // Write then read-back on m0; byte-masked m1 write then m0 read.
    vecs.push_back(mk(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, '0, '0, '0, 1));
    vecs.push_back(mk(1, 0, 12'h010, '0, '0, 0, 0, '0, '0, '0, 1));
    vecs.push_back(idle());
    vecs.push_back(mk(0, 0, '0, '0, '0, 0, 1, 12'h020, 32'hFFFFFFFF, 4'hF, 2));
    vecs.push_back(mk(0, 0, '0, '0, '0, 0, 1, 12'h020, 32'h12345678, 4'h3, 2));
    vecs.push_back(mk(1, 0, 12'h020, '0, '0, 0, 0, '0, '0, '0, 1));
    vecs.push_back(idle());
    // Continuous contention: m0 x4, m1 x4, m0 x4.
    for (int i = 0; i < 12; i++)
      vecs.push_back(mk(1, 0, 12'h010, '0, '0, 1, 0, 12'h020, '0, '0, (i < 4 || i >= 8) ? 1 : 2));
    vecs.push_back(idle());
    // Idle cycle clears the hold count, so m0 wins four more grants.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 12'h010, '0, '0, 0, 0, '0, '0, '0, 1));
    vecs.push_back(idle());
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 12'h010, '0, '0, 1, 0, 12'h020, '0, '0, (i < 4) ? 1 : 2));
    vecs.push_back(idle());

    reset_cycle(0, 0);
    reset_cycle(0, 0);
    foreach (vecs[i]) drive(vecs[i]);

    // Read accepted just before reset is dropped; first tie afterwards goes to m0.
    drive(mk(1, 0, 12'hFFF, '0, '0, 0, 0, '0, '0, '0, 1));
    reset_cycle(1, 1);
    drive(mk(1, 0, 12'h010, '0, '0, 1, 0, 12'h020, '0, '0, 1));
    drive(idle());
    drive(mk(0, 0, '0, '0, '0, 1, 0, 12'h020, '0, '0, 2));
    drive(mk(0, 0, '0, '0, '0, 1, 0, 12'h020, '0, '0, 2));
    reset_cycle(1, 1);
    drive(mk(1, 0, 12'h010, '0, '0, 1, 0, 12'h020, '0, '0, 1));
    drive(idle());
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    // MAX_HOLD=1 instance: both write every cycle, strict alternation.
    reset_cycle(0, 0);
    for (int i = 0; i < 8; i++) begin
      reset = 1'b0;
      m0_read = 0; m0_write = 1; m0_address = 12'(12'h100 + i);
      m0_writedata = 32'hA000_0000 + i; m0_byteenable = 4'hF;
      m1_read = 0; m1_write = 1; m1_address = 12'(12'h200 + i);
      m1_writedata = 32'hB000_0000 + i; m1_byteenable = 4'h5;
      @(negedge clk);
      chk1("alt_m0_waitrequest", alt_m0_waitrequest, (i % 2) == 1);
      chk1("alt_m1_waitrequest", alt_m1_waitrequest, (i % 2) == 0);
      chk1("alt_mem_chipselect", alt_mem_chipselect, 1'b1);
      chk1("alt_mem_write", alt_mem_write, 1'b1);
      chk("alt_mem_address", 32'(alt_mem_address), (i % 2) == 0 ? 32'(12'h100 + i) : 32'(12'h200 + i));
      chk("alt_mem_writedata", alt_mem_writedata, (i % 2) == 0 ? 32'hA000_0000 + i : 32'hB000_0000 + i);
      chk("alt_mem_byteenable", 32'(alt_mem_byteenable), (i % 2) == 0 ? 32'hF : 32'h5);
      chk1("alt_m0_readdatavalid", alt_m0_readdatavalid, 1'b0);
      chk1("alt_m1_readdatavalid", alt_m1_readdatavalid, 1'b0);
      chk("alt_m0_readdata", alt_m0_readdata, 32'h0BAD_F00D);
      chk("alt_m1_readdata", alt_m1_readdata, 32'h0BAD_F00D);
      @(posedge clk); #1;
      cyc++;
    end
    m0_write = 0; m1_write = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
